// File: rtl/pc_fetch_sequencer.sv
// PC next-value selection and imem fetch handshake sequencer.
// Holds redirects that arrive while a fetch is stalled and times out fetches that never return.
module pc_fetch_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0080),
  parameter int                MAX_WAIT  = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              imem_ready_i,
  input  logic              hazard_stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              exc_i,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              pc_write_o,
  output logic              imem_req_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              imem_err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;

  logic              redir;
  logic [ADDR_W-1:0] redir_target;
  logic [8:0]        cnt_inc;
  logic              timeout;

  assign redir        = exc_i | branch_taken_i | jump_i;
  assign redir_target = exc_i ? EXC_VEC : (branch_taken_i ? branch_target_i : jump_target_i);
  assign cnt_inc      = {1'b0, wait_cnt_q} + 9'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_BOOT;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    wait_cnt_d    = wait_cnt_q;
    timeout       = 1'b0;
    pc_next_o     = pc_i + ADDR_W'(4);
    pc_write_o    = 1'b0;
    imem_req_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    imem_err_o    = 1'b0;
    state_o       = state_q;

    unique case (state_q)
      S_BOOT: begin
        pc_next_o    = RESET_VEC;
        pc_write_o   = 1'b1;
        ifid_flush_o = 1'b1;
        state_d      = S_FETCH;
        wait_cnt_d   = '0;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          if (redir) begin
            pc_next_o    = redir_target;
            pc_write_o   = 1'b1;
            ifid_flush_o = 1'b1;
          end else if (!hazard_stall_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
        end else if (MAX_WAIT == 1) begin
          timeout = 1'b1;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = 8'd1;
          if (redir) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redir_target;
          end
        end
      end
      S_WAIT: begin
        imem_req_o = 1'b1;
        if (!imem_ready_i) begin
          if (cnt_inc == 9'(MAX_WAIT)) begin
            timeout = 1'b1;
          end else begin
            wait_cnt_d = cnt_inc[7:0];
            // An exception always replaces what is held; a later branch/jump never does.
            if (exc_i) begin
              pend_valid_d  = 1'b1;
              pend_target_d = EXC_VEC;
            end else if (redir && !pend_valid_q) begin
              pend_valid_d  = 1'b1;
              pend_target_d = redir_target;
            end
          end
        end else begin
          state_d       = S_FETCH;
          wait_cnt_d    = '0;
          pend_valid_d  = 1'b0;
          pend_target_d = '0;
          if (exc_i || pend_valid_q || redir) begin
            pc_next_o    = exc_i ? EXC_VEC : (pend_valid_q ? pend_target_q : redir_target);
            pc_write_o   = 1'b1;
            ifid_flush_o = 1'b1;
          end else if (!hazard_stall_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase

    if (timeout) begin
      imem_err_o    = 1'b1;
      pc_next_o     = EXC_VEC;
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      pend_valid_d  = 1'b0;
      pend_target_d = '0;
      wait_cnt_d    = '0;
      state_d       = S_FETCH;
    end

    // Reset forces quiet outputs even though the state already reads BOOT.
    if (rst_i) begin
      pc_next_o    = RESET_VEC;
      pc_write_o   = 1'b0;
      imem_req_o   = 1'b0;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b0;
      imem_err_o   = 1'b0;
      state_o      = 2'd0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: hand-computed expectations checked with immediate assertions.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ready, stall, br, jmp, exc;
  logic [31:0] bt, jt;
  logic [31:0] pc_next;
  logic        pc_write, req, ifid_wr, ifid_fl, err;
  logic [1:0]  st;

  int checks = 0;
  int errors = 0;

  pc_fetch_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pc_i           (pc),
    .imem_ready_i   (ready),
    .hazard_stall_i (stall),
    .branch_taken_i (br),
    .branch_target_i(bt),
    .jump_i         (jmp),
    .jump_target_i  (jt),
    .exc_i          (exc),
    .pc_next_o      (pc_next),
    .pc_write_o     (pc_write),
    .imem_req_o     (req),
    .ifid_write_o   (ifid_wr),
    .ifid_flush_o   (ifid_fl),
    .imem_err_o     (err),
    .state_o        (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compares every output; -1 in pcn skips pc_next (don't care when pc_write=0).
  task automatic expect_o(input string tag, input logic [32:0] pcn, input logic pw,
                          input logic rq, input logic wr, input logic fl,
                          input logic er, input logic [1:0] s);
    if (!pcn[32]) check({tag, ".pc_next"}, pc_next, pcn[31:0]);
    check({tag, ".pc_write"}, {31'd0, pc_write}, {31'd0, pw});
    check({tag, ".imem_req"}, {31'd0, req}, {31'd0, rq});
    check({tag, ".ifid_write"}, {31'd0, ifid_wr}, {31'd0, wr});
    check({tag, ".ifid_flush"}, {31'd0, ifid_fl}, {31'd0, fl});
    check({tag, ".imem_err"}, {31'd0, err}, {31'd0, er});
    check({tag, ".state"}, {30'd0, st}, {30'd0, s});
    $display("step %-14s pc_i=%h ready=%0b pc_next=%h pw=%0b req=%0b wr=%0b fl=%0b err=%0b st=%0d",
             tag, pc, ready, pc_next, pc_write, req, ifid_wr, ifid_fl, err, st);
  endtask

  task automatic drive(input logic [31:0] p, input logic rdy, input logic stl,
                       input logic b, input logic [31:0] btgt,
                       input logic j, input logic [31:0] jtgt, input logic e);
    pc = p; ready = rdy; stall = stl; br = b; bt = btgt; jmp = j; jt = jtgt; exc = e;
    #1;
  endtask

  localparam logic [32:0] DC = 33'h1_0000_0000;

  initial begin
    rst = 1'b1;
    drive(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); #1;
    expect_o("reset", 33'h0, 0, 0, 0, 0, 0, 2'd0);

    // BOOT ignores a jump request.
    @(negedge clk); rst = 1'b0;
    drive(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    expect_o("boot", 33'h0, 1, 0, 0, 1, 0, 2'd0);

    @(negedge clk); drive(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("seq4", 33'h4, 1, 1, 1, 0, 0, 2'd1);
    @(negedge clk); drive(32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("seq8", 33'h8, 1, 1, 1, 0, 0, 2'd1);
    @(negedge clk); drive(32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("seqC", 33'hC, 1, 1, 1, 0, 0, 2'd1);

    // Redirect priority.
    @(negedge clk); drive(32'h10, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h60, 1'b0);
    expect_o("br_over_jmp", 33'h40, 1, 1, 0, 1, 0, 2'd1);
    @(negedge clk); drive(32'h10, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h60, 1'b1);
    expect_o("exc_over_br", 33'h80, 1, 1, 0, 1, 0, 2'd1);
    @(negedge clk); drive(32'h10, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h60, 1'b0);
    expect_o("jump", 33'h60, 1, 1, 0, 1, 0, 2'd1);

    // Hazard stall for two cycles, then advance; stall never blocks a redirect.
    @(negedge clk); drive(32'h30, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("stall1", DC, 0, 1, 0, 0, 0, 2'd1);
    @(negedge clk); drive(32'h30, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("stall2", DC, 0, 1, 0, 0, 0, 2'd1);
    @(negedge clk); drive(32'h30, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("unstall", 33'h34, 1, 1, 1, 0, 0, 2'd1);
    @(negedge clk); drive(32'h30, 1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0);
    expect_o("stall_br", 33'h44, 1, 1, 0, 1, 0, 2'd1);

    @(negedge clk); drive(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("wrap", 33'h0, 1, 1, 1, 0, 0, 2'd1);

    // Wait with a jump arriving in the second wait cycle.
    @(negedge clk); drive(32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("w_fetch", DC, 0, 1, 0, 0, 0, 2'd1);
    @(negedge clk); drive(32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("w_wait1", DC, 0, 1, 0, 0, 0, 2'd2);
    @(negedge clk); drive(32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    expect_o("w_wait2", DC, 0, 1, 0, 0, 0, 2'd2);
    @(negedge clk); drive(32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("w_ready", 33'h100, 1, 1, 0, 1, 0, 2'd2);
    @(negedge clk); drive(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("w_after", 33'h104, 1, 1, 1, 0, 0, 2'd1);

    // First latched redirect is kept and beats a redirect on the ready cycle.
    @(negedge clk); drive(32'h20, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    expect_o("p_latch", DC, 0, 1, 0, 0, 0, 2'd1);
    @(negedge clk); drive(32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
    expect_o("p_keep", DC, 0, 1, 0, 0, 0, 2'd2);
    @(negedge clk); drive(32'h20, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    expect_o("p_resolve", 33'h300, 1, 1, 0, 1, 0, 2'd2);

    // Exception during wait overwrites a pending branch.
    @(negedge clk); drive(32'h20, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    expect_o("e_latch", DC, 0, 1, 0, 0, 0, 2'd1);
    @(negedge clk); drive(32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    expect_o("e_exc", DC, 0, 1, 0, 0, 0, 2'd2);
    @(negedge clk); drive(32'h20, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    expect_o("e_resolve", 33'h80, 1, 1, 0, 1, 0, 2'd2);

    // Timeout: 15 consecutive not-ready cycles, jump pending on the way.
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      drive(32'h50, 1'b0, 1'b0, 1'b0, 32'h0, (i == 5), 32'h600, 1'b0);
      if (i < 15)
        expect_o($sformatf("to_c%0d", i), DC, 0, 1, 0, 0, 0, (i == 1) ? 2'd1 : 2'd2);
      else
        expect_o("to_c15", 33'h80, 1, 1, 0, 1, 1, 2'd2);
    end
    @(negedge clk); drive(32'h80, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("to_after", 33'h84, 1, 1, 1, 0, 0, 2'd1);

    // Reset in the middle of a wait with a redirect pending.
    @(negedge clk); drive(32'h20, 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
    expect_o("r_latch", DC, 0, 1, 0, 0, 0, 2'd1);
    @(negedge clk); drive(32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("r_wait", DC, 0, 1, 0, 0, 0, 2'd2);
    #1 rst = 1'b1; #1;
    expect_o("r_async", 33'h0, 0, 0, 0, 0, 0, 2'd0);
    @(negedge clk); rst = 1'b0;
    drive(32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("r_boot", 33'h0, 1, 0, 0, 1, 0, 2'd0);
    @(negedge clk); drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("r_fetch", DC, 0, 1, 0, 0, 0, 2'd1);
    @(negedge clk); drive(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_o("r_nopend", 33'h4, 1, 1, 1, 0, 0, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
